// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array feed sequencer: array geometry
// defaults, the sequencer state encoding and lane slicing helpers.
package systolic_pkg;

    localparam int SYS_N      = 8;
    localparam int SYS_DW     = 32;
    localparam int SYS_RD_LAT = 1;

    // Cycles after the last read until the last operand pair has been
    // accumulated in the far corner PE.
    function automatic int drain_cycles(input int rd_lat, input int n);
        return rd_lat + 2 * n - 1;
    endfunction

    localparam int DRAIN_CYC = drain_cycles(SYS_RD_LAT, SYS_N);

    // Low bit of lane `lane` inside a packed N*dw operand bus.
    function automatic int lane_lo(input int lane, input int dw);
        return lane * dw;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FLUSH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_WB    = 3'd4,
        ST_FIN   = 3'd5
    } state_t;

endpackage

// File: rtl/systolic_feed_ctrl_skew_line.sv
// Zero-reset delay line used to skew one operand lane; DEPTH=0 is a wire.
module skew_line #(
    parameter int DEPTH = 0,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] i_d,
    output logic [DW-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic w_unused;
            assign w_unused = clk ^ rst_n;
            assign o_q      = i_d;
        end else begin : g_pipe
            logic [DW-1:0] r_stage [DEPTH];

            // Shift the lane one stage per clock; reset flushes to zero.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s < DEPTH; s++) r_stage[s] <= '0;
                end else begin
                    r_stage[0] <= i_d;
                    for (int s = 1; s < DEPTH; s++) r_stage[s] <= r_stage[s-1];
                end
            end

            assign o_q = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Feed sequencer for the NxN systolic matmul array: flushes the array,
// streams K operand columns/rows from the A and B BRAMs with per-lane skew,
// drains the pipeline, then requests writeback and reports completion.
//
// state | meaning
// IDLE  | waiting for start
// FLUSH | one cycle clearing PE accumulators and writer counter
// LOAD  | K cycles of BRAM reads, address = step counter
// DRAIN | D cycles letting the last operands reach PE(N-1,N-1)
// WB    | complete_matmul held until result_w_comp
// FIN   | one-cycle done (and err when K was 0)
module systolic_feed_ctrl
    import systolic_pkg::*;
#(
    parameter int N      = SYS_N,
    parameter int DW     = SYS_DW,
    parameter int AW     = 9,
    parameter int RD_LAT = SYS_RD_LAT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [AW:0]     k_len,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic            a_rd_en,
    output logic [AW-1:0]   a_rd_addr,
    input  logic [N*DW-1:0] a_rd_data,
    output logic            b_rd_en,
    output logic [AW-1:0]   b_rd_addr,
    input  logic [N*DW-1:0] b_rd_data,
    output logic [N*DW-1:0] west_data,
    output logic [N*DW-1:0] north_data,
    output logic            arr_valid,
    output logic            arr_flush,
    output logic            complete_matmul,
    input  logic            result_w_comp
);

    localparam int D_CYC = drain_cycles(RD_LAT, N);
    localparam int CW    = AW + 1;

    state_t          r_state;
    logic            r_busy;
    logic            r_done;
    logic            r_err;
    logic            r_rd_en;
    logic            r_valid;
    logic            r_flush;
    logic            r_cmm;
    logic [AW-1:0]   r_addr;
    logic [AW:0]     r_cnt;
    logic [AW:0]     r_k;
    logic [RD_LAT-1:0] r_vld;

    logic [AW:0]     w_cnt_inc;
    logic            w_load_last;
    logic            w_drain_last;
    logic            w_cap_vld;
    logic [N*DW-1:0] w_a_cap;
    logic [N*DW-1:0] w_b_cap;
    logic [N*DW-1:0] w_west;
    logic [N*DW-1:0] w_north;

    assign w_cnt_inc    = r_cnt + 1'b1;
    assign w_load_last  = (r_cnt == (r_k - 1'b1));
    assign w_drain_last = (r_cnt == '0);

    // Sequencer: next state and all registered control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_rd_en <= 1'b0;
            r_valid <= 1'b0;
            r_flush <= 1'b0;
            r_cmm   <= 1'b0;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_k     <= '0;
        end else begin
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_flush <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        r_k    <= k_len;
                        if (k_len == '0) begin
                            // Empty job: skip the array entirely and report.
                            r_state <= ST_FIN;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            r_state <= ST_FLUSH;
                            r_flush <= 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    r_state <= ST_LOAD;
                    r_rd_en <= 1'b1;
                    r_valid <= 1'b1;
                    r_addr  <= '0;
                    r_cnt   <= '0;
                end
                ST_LOAD: begin
                    if (w_load_last) begin
                        r_state <= ST_DRAIN;
                        r_rd_en <= 1'b0;
                        r_addr  <= '0;
                        r_cnt   <= CW'(D_CYC - 1);
                    end else begin
                        r_cnt  <= w_cnt_inc;
                        r_addr <= w_cnt_inc[AW-1:0];
                    end
                end
                ST_DRAIN: begin
                    if (w_drain_last) begin
                        r_state <= ST_WB;
                        r_valid <= 1'b0;
                        r_cmm   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_WB: begin
                    if (result_w_comp) begin
                        r_state <= ST_FIN;
                        r_cmm   <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_rd_en <= 1'b0;
                    r_valid <= 1'b0;
                    r_cmm   <= 1'b0;
                end
            endcase
        end
    end

    // Track which cycles carry returned BRAM data (RD_LAT after the enable).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= r_rd_en;
            for (int s = 1; s < RD_LAT; s++) r_vld[s] <= r_vld[s-1];
        end
    end

    // Capture is a zero mask on the BRAM outputs so idle cycles feed zeros
    // and lane 0 sees read data in the same cycle it returns.
    assign w_cap_vld = r_vld[RD_LAT-1];
    assign w_a_cap   = w_cap_vld ? a_rd_data : '0;
    assign w_b_cap   = w_cap_vld ? b_rd_data : '0;

    generate
        for (genvar g = 0; g < N; g++) begin : g_lane
            skew_line #(
                .DEPTH (g),
                .DW    (DW)
            ) u_west (
                .clk   (clk),
                .rst_n (rst_n),
                .i_d   (w_a_cap[lane_lo(g, DW) +: DW]),
                .o_q   (w_west[lane_lo(g, DW) +: DW])
            );

            skew_line #(
                .DEPTH (g),
                .DW    (DW)
            ) u_north (
                .clk   (clk),
                .rst_n (rst_n),
                .i_d   (w_b_cap[lane_lo(g, DW) +: DW]),
                .o_q   (w_north[lane_lo(g, DW) +: DW])
            );
        end
    endgenerate

    assign busy            = r_busy;
    assign done            = r_done;
    assign err             = r_err;
    assign a_rd_en         = r_rd_en;
    assign b_rd_en         = r_rd_en;
    assign a_rd_addr       = r_addr;
    assign b_rd_addr       = r_addr;
    assign west_data       = w_west;
    assign north_data      = w_north;
    assign arr_valid       = r_valid;
    assign arr_flush       = r_flush;
    assign complete_matmul = r_cmm;

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Scoreboard bench for systolic_feed_ctrl: BRAM and PE-grid models around
// the DUT, expected job results from plain matrix arithmetic.
module tb_systolic_feed_ctrl;

    localparam int N      = 8;
    localparam int DW     = 32;
    localparam int AW     = 9;
    localparam int RD_LAT = 1;
    localparam int D      = RD_LAT + 2 * N - 1;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [AW:0]     k_len;
    logic            busy, done, err;
    logic            a_rd_en, b_rd_en;
    logic [AW-1:0]   a_rd_addr, b_rd_addr;
    logic [N*DW-1:0] a_rd_data, b_rd_data;
    logic [N*DW-1:0] west_data, north_data;
    logic            arr_valid, arr_flush, complete_matmul;
    logic            result_w_comp;

    systolic_feed_ctrl #(.N(N), .DW(DW), .AW(AW), .RD_LAT(RD_LAT)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .k_len           (k_len),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .a_rd_en         (a_rd_en),
        .a_rd_addr       (a_rd_addr),
        .a_rd_data       (a_rd_data),
        .b_rd_en         (b_rd_en),
        .b_rd_addr       (b_rd_addr),
        .b_rd_data       (b_rd_data),
        .west_data       (west_data),
        .north_data      (north_data),
        .arr_valid       (arr_valid),
        .arr_flush       (arr_flush),
        .complete_matmul (complete_matmul),
        .result_w_comp   (result_w_comp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input longint act, input longint expv);
        n_chk++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic finish_run();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    endtask

    function automatic logic [31:0] lane(input logic [N*DW-1:0] w, input int i);
        return w[i*DW +: DW];
    endfunction

    // Operand BRAMs, one cycle read latency.
    logic [N*DW-1:0] mem_a [1<<AW];
    logic [N*DW-1:0] mem_b [1<<AW];
    always @(posedge clk) begin
        if (a_rd_en) a_rd_data <= mem_a[a_rd_addr];
        if (b_rd_en) b_rd_data <= mem_b[b_rd_addr];
    end

    // Output-stationary PE grid: A moves east, B moves south.
    logic [31:0] pe_a [N][N];
    logic [31:0] pe_b [N][N];
    logic [31:0] pe_acc [N][N];
    logic [31:0] ain, bin;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || arr_flush) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    pe_a[i][j]   <= '0;
                    pe_b[i][j]   <= '0;
                    pe_acc[i][j] <= '0;
                end
        end else if (arr_valid) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    if (j == 0) ain = west_data[i*DW +: DW];
                    else        ain = pe_a[i][j-1];
                    if (i == 0) bin = north_data[j*DW +: DW];
                    else        bin = pe_b[i-1][j];
                    pe_acc[i][j] <= pe_acc[i][j] + ain * bin;
                    pe_a[i][j]   <= ain;
                    pe_b[i][j]   <= bin;
                end
        end
    end

    typedef struct packed {
        logic [31:0]              start_cyc;
        logic [31:0]              k;
        logic [31:0]              w;
        logic [31:0]              w3_off;
        logic [N*N-1:0][31:0]     c;
    } exp_t;

    exp_t exp_q[$];

    // Result writer: answers complete_matmul after wr_dly cycles; with
    // wr_dly==0 it holds result_w_comp high before WB is even entered.
    int wr_dly = 0;
    int wb_n   = 0;
    initial begin
        result_w_comp = 1'b0;
        forever begin
            @(negedge clk);
            if (complete_matmul) begin
                wb_n++;
                result_w_comp = (wb_n > wr_dly);
            end else begin
                wb_n = 0;
                result_w_comp = (wr_dly == 0);
            end
        end
    end

    // Monitor: accumulates per-job observations and scores them on done.
    int rd_cnt, addr_bad, val_cnt, fl_cnt, fl_cyc, cm_cnt, w3_cyc, err_stray;
    int n_done = 0;
    bit chk_idle = 0;

    function automatic void clear_acc();
        rd_cnt = 0; addr_bad = 0; val_cnt = 0; fl_cnt = 0; fl_cyc = 0;
        cm_cnt = 0; w3_cyc = 0; err_stray = 0;
    endfunction

    initial begin
        exp_t e;
        int   st, k, bad_i, bad_j;
        clear_acc();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                clear_acc();
                chk_idle = 0;
                continue;
            end
            if (chk_idle) begin
                chk("idle_after_done", busy, 0);
                chk_idle = 0;
            end
            if (a_rd_en) begin
                if (!b_rd_en || a_rd_addr != AW'(rd_cnt) || b_rd_addr != a_rd_addr) addr_bad++;
                rd_cnt++;
            end else if (b_rd_en) begin
                addr_bad++;
            end
            if (arr_valid) val_cnt++;
            if (arr_flush) begin
                if (fl_cnt == 0) fl_cyc = cyc;
                fl_cnt++;
            end
            if (complete_matmul) cm_cnt++;
            if (w3_cyc == 0 && west_data[3*DW +: DW] != 0) w3_cyc = cyc;
            if (err && !done) err_stray++;
            if (done) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_done: got done at cycle %0d expected no job", cyc);
                end else begin
                    e  = exp_q.pop_front();
                    st = int'(e.start_cyc);
                    k  = int'(e.k);
                    chk("done_time",   cyc - st, (k > 0) ? (1 + k + D + int'(e.w) + 1) : 1);
                    chk("err_pulse",   err, (k == 0) ? 1 : 0);
                    chk("err_stray",   err_stray, 0);
                    chk("read_count",  rd_cnt, k);
                    chk("addr_seq",    addr_bad, 0);
                    chk("flush_count", fl_cnt, (k > 0) ? 1 : 0);
                    if (k > 0) chk("flush_time", fl_cyc - st, 1);
                    chk("valid_cycles", val_cnt, (k > 0) ? (k + D) : 0);
                    chk("wb_cycles",   cm_cnt, int'(e.w));
                    chk("lane3_first", (w3_cyc == 0) ? 0 : (w3_cyc - st), int'(e.w3_off));
                    if (k > 0) begin
                        bad_i = -1; bad_j = -1;
                        for (int i = 0; i < N; i++)
                            for (int j = 0; j < N; j++)
                                if (bad_i < 0 && pe_acc[i][j] !== e.c[i*N+j]) begin
                                    bad_i = i; bad_j = j;
                                end
                        n_chk++;
                        if (bad_i >= 0) begin
                            n_err++;
                            $display("FAIL result_matrix: C[%0d][%0d] got %0d expected %0d (k=%0d)",
                                     bad_i, bad_j, pe_acc[bad_i][bad_j], e.c[bad_i*N+bad_j], k);
                        end
                    end
                end
                clear_acc();
                chk_idle = 1;
            end
        end
    end

    task automatic chk_outputs_zero(input string nm);
        chk(nm, {busy, done, err, a_rd_en, b_rd_en, arr_valid, arr_flush, complete_matmul}, 0);
        chk({nm, "_data"}, ((west_data != 0) || (north_data != 0) ||
                            (a_rd_addr != 0) || (b_rd_addr != 0)) ? 1 : 0, 0);
    endtask

    // Load operands, push the expected job outcome, issue start and wait.
    // mode: 0 random, 1 identity A with B[k][j]=k*8+j.
    task automatic run_job(input int k, input int dly, input int mode, input bit poke);
        exp_t        e;
        logic [31:0] acc;
        int          limit;
        bit          seen;
        for (int kk = 0; kk < k; kk++) begin
            for (int i = 0; i < N; i++) begin
                if (mode == 1) begin
                    mem_a[kk][i*DW +: DW] = (i == kk) ? 32'd1 : 32'd0;
                    mem_b[kk][i*DW +: DW] = 32'(kk * 8 + i);
                end else begin
                    mem_a[kk][i*DW +: DW] = $urandom_range(0, 15);
                    mem_b[kk][i*DW +: DW] = $urandom_range(0, 15);
                end
            end
        end
        e = '0;
        e.k = 32'(k);
        e.w = (k > 0) ? 32'(dly + 1) : 32'd0;
        for (int kk = k - 1; kk >= 0; kk--)
            if (lane(mem_a[kk], 3) != 0) e.w3_off = 32'(2 + kk + RD_LAT + 3);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                acc = '0;
                for (int kk = 0; kk < k; kk++) acc = acc + lane(mem_a[kk], i) * lane(mem_b[kk], j);
                e.c[i*N+j] = acc;
            end
        wr_dly = dly;
        @(negedge clk);
        e.start_cyc = 32'(cyc);
        exp_q.push_back(e);
        start = 1'b1;
        k_len = (AW+1)'(k);
        @(negedge clk);
        start = 1'b0;
        k_len = (AW+1)'($urandom_range(1, 1023));
        limit = k + D + dly + 40;
        if (poke && k > 0) begin
            seen = 0;
            for (int t = 0; t < limit && !seen; t++) begin
                if (arr_valid && !a_rd_en) begin
                    seen  = 1;
                    start = 1'b1;
                    k_len = (AW+1)'($urandom_range(1, 600));
                    @(negedge clk);
                    start = 1'b0;
                end else begin
                    @(negedge clk);
                end
            end
            if (!seen) begin
                n_chk++; n_err++;
                $display("FAIL drain_timeout: no drain phase within %0d cycles (k=%0d)", limit, k);
                finish_run();
            end
        end
        seen = 0;
        for (int t = 0; t < limit && !seen; t++) begin
            if (done) seen = 1;
            else @(negedge clk);
        end
        if (!seen) begin
            n_chk++; n_err++;
            $display("FAIL done_timeout: no done within %0d cycles (k=%0d)", limit, k);
            finish_run();
        end
        if (poke) begin
            start = 1'b1;
            k_len = (AW+1)'($urandom_range(1, 600));
        end
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int saved;
        rst_n = 1'b0;
        start = 1'b0;
        k_len = '0;
        a_rd_data = '0;
        b_rd_data = '0;
        for (int a = 0; a < (1 << AW); a++) begin
            mem_a[a] = '0;
            mem_b[a] = '0;
        end
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset_outputs");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_job(8, 3, 1, 0);
        run_job(1, 0, 0, 0);
        run_job(0, 2, 0, 0);
        run_job(8, 70, 0, 0);

        // Abandon a job mid-LOAD with reset.
        for (int kk = 0; kk < 8; kk++) mem_a[kk] = {N{32'd5}};
        wr_dly = 2;
        @(negedge clk);
        start = 1'b1;
        k_len = (AW+1)'(8);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("in_load_before_reset", a_rd_en, 1);
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("midjob_reset_outputs");
        exp_q.delete();
        saved = n_done;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("no_done_after_reset", n_done, saved);
        chk("idle_after_reset", busy, 0);

        run_job(5, 1, 0, 0);
        run_job(6, 2, 0, 1);
        run_job(512, $urandom_range(0, 5), 0, 0);
        for (int r = 0; r < 6; r++)
            run_job($urandom_range(1, 40), $urandom_range(0, 6), 0, 1'($urandom_range(0, 1)));

        repeat (4) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        finish_run();
    end

endmodule
